// File: rtl/uart_tx_byte.sv
// Byte-wide UART transmitter: 8-N-1 framing with optional even parity.
// A byte is accepted on valid_in && ready_out and shifted out LSB-first on tx_out.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy_out
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shreg_q;
  logic            par_q;
  logic            tx_q;
  logic            busy_q;

  logic            bit_done;

  assign bit_done  = (cnt_q == CntMax);
  // Depends only on registered state plus ena/rst, never on valid_in.
  assign ready_out = (state_q == StIdle) && ena && !rst;
  assign tx_out    = tx_q;
  assign busy_out  = busy_q;

  // Frame sequencer: state, baud/bit counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else if (ena) begin
      case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          if (valid_in) begin
            shreg_q <= data_in;
            par_q   <= (PARITY_EN != 0) ? ^data_in : 1'b0;
            idx_q   <= '0;
            state_q <= StStart;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        StStart: begin
          if (bit_done) begin
            cnt_q   <= '0;
            state_q <= StData;
            tx_q    <= shreg_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StData: begin
          if (bit_done) begin
            cnt_q   <= '0;
            shreg_q <= {1'b0, shreg_q[7:1]};
            if (idx_q == 3'd7) begin
              idx_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= StParity;
                tx_q    <= par_q;
              end else begin
                state_q <= StStop;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
              // Next data bit sits at [1] before this shift lands.
              tx_q  <= shreg_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StParity: begin
          if (bit_done) begin
            cnt_q   <= '0;
            state_q <= StStop;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StStop: begin
          if (bit_done) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          idx_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
